// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI burst RAM slave: FSM states, command codes
// and elaboration-time helpers.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHK_CMD = 3'd1,
    WR_ADDR = 3'd2,
    WR_DATA = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_ram_core.sv
// Single-port synchronous RAM; the read port registers the addressed word
// every cycle (read-before-write when we is high). Contents are never reset.
module spi_ram_core #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] dout
);

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/spi_ram_burst.sv
// SPI slave in front of an on-chip RAM: 2-bit command, address loads into
// independent write/read pointers, and back-to-back burst data in both directions.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned AUTO_INC  = 1
) (
  input  logic clk,
  input  logic RST,
  input  logic SS_N,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_err
);

  localparam int unsigned SH_W  = max_u(ADDR_SIZE, DATA_SIZE);
  localparam int unsigned CNT_W = (SH_W > 2) ? $clog2(SH_W) : 1;
  localparam logic [CNT_W-1:0]     ADDR_LAST = CNT_W'(ADDR_SIZE - 1);
  localparam logic [CNT_W-1:0]     DATA_LAST = CNT_W'(DATA_SIZE - 1);
  localparam logic [ADDR_SIZE-1:0] PTR_LAST  = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE:0]   DEPTH     = (ADDR_SIZE + 1)'(MEM_DEPTH);

  function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [ADDR_SIZE-1:0] ptr_load(input logic [ADDR_SIZE-1:0] a);
    return ADDR_SIZE'({1'b0, a} % DEPTH);
  endfunction

  state_e               state_q, state_d;
  logic [SH_W-2:0]      sh_q, sh_d;
  logic [SH_W-1:0]      sh_nxt;
  logic [DATA_SIZE-1:0] rd_sh_q, rd_sh_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cmd_hi_q, cmd_hi_d;
  logic                 done_q, done_d;
  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic                 miso_q, miso_d;
  logic                 busy_q, busy_d;
  logic                 ferr_q, ferr_d;
  logic                 ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [DATA_SIZE-1:0] ram_dout;

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    rd_sh_d  = rd_sh_q;
    cnt_d    = cnt_q;
    cmd_hi_d = cmd_hi_q;
    done_d   = done_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    miso_d   = 1'b0;
    ferr_d   = 1'b0;
    ram_we   = 1'b0;
    sh_nxt   = {sh_q, MOSI};
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        done_d = 1'b0;
        if (!SS_N) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_N) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          cmd_hi_d = MOSI;
          cnt_d    = CNT_W'(1);
        end else begin
          cnt_d  = '0;
          done_d = 1'b0;
          unique case ({cmd_hi_q, MOSI})
            CMD_WR_ADDR: state_d = WR_ADDR;
            CMD_WR_DATA: state_d = WR_DATA;
            CMD_RD_ADDR: state_d = RD_ADDR;
            default:     state_d = RD_DATA;
          endcase
        end
      end
      WR_ADDR, RD_ADDR: begin
        if (SS_N) begin
          state_d = IDLE;
          ferr_d  = (cnt_q != '0);
          cnt_d   = '0;
        end else if (!done_q) begin
          sh_d = sh_nxt[SH_W-2:0];
          if (cnt_q == ADDR_LAST) begin
            cnt_d  = '0;
            done_d = 1'b1;
            if (state_q == WR_ADDR) wr_ptr_d = ptr_load(sh_nxt[ADDR_SIZE-1:0]);
            else                    rd_ptr_d = ptr_load(sh_nxt[ADDR_SIZE-1:0]);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WR_DATA: begin
        if (SS_N) begin
          state_d = IDLE;
          ferr_d  = (cnt_q != '0);
          cnt_d   = '0;
        end else begin
          sh_d = sh_nxt[SH_W-2:0];
          if (cnt_q == DATA_LAST) begin
            cnt_d  = '0;
            ram_we = 1'b1;
            if (AUTO_INC != 0) wr_ptr_d = ptr_inc(wr_ptr_q);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RD_DATA: begin
        // cnt_q==0 loads the word the RAM fetched during the previous cycle
        // (the dummy cycle, or the last bit of the previous word).
        if (SS_N) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          miso_d  = ram_dout[DATA_SIZE-1];
          rd_sh_d = {ram_dout[DATA_SIZE-2:0], 1'b0};
          cnt_d   = CNT_W'(1);
        end else begin
          miso_d  = rd_sh_q[DATA_SIZE-1];
          rd_sh_d = {rd_sh_q[DATA_SIZE-2:0], 1'b0};
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
            if (AUTO_INC != 0) rd_ptr_d = ptr_inc(rd_ptr_q);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Reads address the next-cycle pointer so a burst prefetch lands in time.
  assign ram_addr = ram_we ? wr_ptr_q : rd_ptr_d;

  spi_ram_core #(
    .ADDR_SIZE(ADDR_SIZE),
    .DATA_SIZE(DATA_SIZE),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_core (
    .clk (clk),
    .we  (ram_we & ~RST),
    .addr(ram_addr),
    .din (sh_nxt[DATA_SIZE-1:0]),
    .dout(ram_dout)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      rd_sh_q  <= '0;
      cnt_q    <= '0;
      cmd_hi_q <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      miso_q   <= 1'b0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      rd_sh_q  <= rd_sh_d;
      cnt_q    <= cnt_d;
      cmd_hi_q <= cmd_hi_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      miso_q   <= miso_d;
      busy_q   <= busy_d;
      ferr_q   <= ferr_d;
    end
  end

  assign MISO      = miso_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst: an auto-increment build and a hold-pointer
// build share the SPI inputs; read data is checked against per-DUT scoreboards.
module tb_spi_ram_burst;

  logic clk = 1'b0;
  logic RST = 1'b1;
  logic SS_N = 1'b1;
  logic MOSI = 1'b0;
  logic miso1, busy1, ferr1;
  logic miso0, busy0, ferr0;

  int checks = 0;
  int errors = 0;
  int ferr_cnt1 = 0;
  int ferr_cnt0 = 0;
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q0[$];

  always #5 clk = ~clk;

  spi_ram_burst #(.ADDR_SIZE(8), .DATA_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut (
    .clk(clk), .RST(RST), .SS_N(SS_N), .MOSI(MOSI),
    .MISO(miso1), .busy(busy1), .frame_err(ferr1)
  );

  spi_ram_burst #(.ADDR_SIZE(8), .DATA_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(0)) dut0 (
    .clk(clk), .RST(RST), .SS_N(SS_N), .MOSI(MOSI),
    .MISO(miso0), .busy(busy0), .frame_err(ferr0)
  );

  always @(posedge clk) begin
    if (ferr1 === 1'b1) ferr_cnt1++;
    if (ferr0 === 1'b1) ferr_cnt0++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one SS_N-low frame; returns at the first cycle after SS_N rises.
  task automatic frame(input logic [1:0] cmd, input logic [31:0] pay,
                       input int unsigned nbits, input int unsigned rd_words,
                       input logic [1:0] mask);
    int unsigned n;
    int unsigned nb;
    logic [7:0] rx1, rx0;
    nb  = 0;
    rx1 = '0;
    rx0 = '0;
    n = (cmd == 2'b11) ? 3 + 8 * rd_words : 3 + nbits;
    for (int unsigned c = 0; c <= n; c++) begin
      @(negedge clk);
      if (c == 2) chk("busy_in_frame", {31'd0, busy1}, 32'd1);
      if (cmd == 2'b11 && c >= 4) begin
        rx1 = {rx1[6:0], miso1};
        rx0 = {rx0[6:0], miso0};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (mask[0]) begin
            if (exp_q1.size() == 0) chk("sb1_empty", 32'd0, 32'd1);
            else chk("rd_word_inc", {24'd0, rx1}, {24'd0, exp_q1.pop_front()});
          end
          if (mask[1]) begin
            if (exp_q0.size() == 0) chk("sb0_empty", 32'd0, 32'd1);
            else chk("rd_word_hold", {24'd0, rx0}, {24'd0, exp_q0.pop_front()});
          end
        end
      end
      if (c == n) begin
        SS_N = 1'b1;
        MOSI = 1'b0;
      end else begin
        SS_N = 1'b0;
        if (c == 0)      MOSI = 1'($urandom);
        else if (c == 1) MOSI = cmd[1];
        else if (c == 2) MOSI = cmd[0];
        else if (cmd == 2'b11) MOSI = 1'($urandom);
        else MOSI = pay[nbits - 1 - (c - 3)];
      end
    end
    @(negedge clk);
    chk("busy_after_frame", {31'd0, busy1}, 32'd0);
  endtask

  initial begin
    logic [3:0] bits4;
    bits4 = '0;
    repeat (3) @(negedge clk);
    chk("rst_miso", {31'd0, miso1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_ferr", {31'd0, ferr1}, 32'd0);
    chk("rst_wr_ptr", {24'd0, dut.wr_ptr_q}, 32'd0);
    chk("rst_rd_ptr", {24'd0, dut.rd_ptr_q}, 32'd0);
    RST = 1'b0;
    @(negedge clk);

    // 1: address load (trailing bits ignored), then two-word write burst
    frame(2'b00, 32'h10F, 12, 0, 2'b00);
    chk("s1_wr_ptr_load", {24'd0, dut.wr_ptr_q}, 32'h10);
    frame(2'b01, 32'hDEAD, 16, 0, 2'b00);
    chk("s1_wr_ptr_inc", {24'd0, dut.wr_ptr_q}, 32'h12);
    chk("s1_wr_ptr_hold", {24'd0, dut0.wr_ptr_q}, 32'h10);
    chk("s1_no_ferr", ferr_cnt1, 0);

    // 2: read back as a contiguous burst
    frame(2'b10, 32'h10, 8, 0, 2'b00);
    exp_q1.push_back(8'hDE); exp_q1.push_back(8'hAD);
    exp_q0.push_back(8'hAD); exp_q0.push_back(8'hAD);
    frame(2'b11, 32'h0, 0, 2, 2'b11);
    chk("s2_rd_ptr_inc", {24'd0, dut.rd_ptr_q}, 32'h12);
    chk("s2_rd_ptr_hold", {24'd0, dut0.rd_ptr_q}, 32'h10);

    // 3: pointer wrap on both write and read bursts
    frame(2'b00, 32'hFF, 8, 0, 2'b00);
    frame(2'b01, 32'h1122, 16, 0, 2'b00);
    chk("s3_wr_ptr_wrap", {24'd0, dut.wr_ptr_q}, 32'h01);
    frame(2'b10, 32'hFF, 8, 0, 2'b00);
    exp_q1.push_back(8'h11); exp_q1.push_back(8'h22);
    exp_q0.push_back(8'h22); exp_q0.push_back(8'h22);
    frame(2'b11, 32'h0, 0, 2, 2'b11);
    chk("s3_rd_ptr_wrap", {24'd0, dut.rd_ptr_q}, 32'h01);
    chk("s3_no_ferr", ferr_cnt1, 0);

    // 4: abort after 5 of 8 data bits
    frame(2'b00, 32'h30, 8, 0, 2'b00);
    frame(2'b01, 32'h5A, 8, 0, 2'b00);
    frame(2'b00, 32'h30, 8, 0, 2'b00);
    frame(2'b01, 32'h13, 5, 0, 2'b00);
    chk("s4_ferr_pulse", {31'd0, ferr1}, 32'd1);
    chk("s4_ferr_pulse_hold", {31'd0, ferr0}, 32'd1);
    chk("s4_busy", {31'd0, busy1}, 32'd0);
    chk("s4_wr_ptr", {24'd0, dut.wr_ptr_q}, 32'h30);
    @(negedge clk);
    chk("s4_ferr_one_cycle", {31'd0, ferr1}, 32'd0);
    chk("s4_ferr_count", ferr_cnt1, 1);
    chk("s4_ferr_count_hold", ferr_cnt0, 1);
    frame(2'b10, 32'h30, 8, 0, 2'b00);
    exp_q1.push_back(8'h5A);
    exp_q0.push_back(8'h5A);
    frame(2'b11, 32'h0, 0, 1, 2'b11);

    // 5: reset while the 4th MISO bit of a read is on the wire
    frame(2'b10, 32'h10, 8, 0, 2'b00);
    for (int unsigned c = 0; c <= 7; c++) begin
      @(negedge clk);
      if (c >= 4) bits4 = {bits4[2:0], miso1};
      SS_N = 1'b0;
      MOSI = (c == 1 || c == 2) ? 1'b1 : 1'b0;
      if (c == 7) RST = 1'b1;
    end
    @(negedge clk);
    chk("s5_bits_before_rst", {28'd0, bits4}, 32'hD);
    chk("s5_miso", {31'd0, miso1}, 32'd0);
    chk("s5_busy", {31'd0, busy1}, 32'd0);
    chk("s5_wr_ptr", {24'd0, dut.wr_ptr_q}, 32'd0);
    chk("s5_rd_ptr", {24'd0, dut.rd_ptr_q}, 32'd0);
    RST = 1'b0;
    SS_N = 1'b1;
    @(negedge clk);
    frame(2'b10, 32'h10, 8, 0, 2'b00);
    exp_q1.push_back(8'hDE);
    exp_q0.push_back(8'hAD);
    frame(2'b11, 32'h0, 0, 1, 2'b11);
    chk("s5_no_ferr", ferr_cnt1, 1);

    // 6: hold-pointer build overwrites one word in place
    frame(2'b00, 32'h21, 8, 0, 2'b00);
    frame(2'b01, 32'h77, 8, 0, 2'b00);
    frame(2'b00, 32'h20, 8, 0, 2'b00);
    frame(2'b01, 32'hAA55, 16, 0, 2'b00);
    chk("s6_wr_ptr_hold", {24'd0, dut0.wr_ptr_q}, 32'h20);
    frame(2'b10, 32'h20, 8, 0, 2'b00);
    exp_q1.push_back(8'hAA); exp_q1.push_back(8'h55);
    exp_q0.push_back(8'h55); exp_q0.push_back(8'h55);
    frame(2'b11, 32'h0, 0, 2, 2'b11);
    frame(2'b10, 32'h21, 8, 0, 2'b00);
    exp_q1.push_back(8'h55);
    exp_q0.push_back(8'h77);
    frame(2'b11, 32'h0, 0, 1, 2'b11);

    chk("sb1_drained", exp_q1.size(), 0);
    chk("sb0_drained", exp_q0.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
- Next-generation SPI slave with on-chip single-port RAM.
- Parametrised in address width, data width and depth.
- Adds multi-word burst transfers with optional address auto-increment, independent write and read pointers, and frame-abort detection.
- Sits between an external SPI master (single clock domain, one bit per clk while SS_N is low) and the on-chip storage.

Parameters:
ADDR_SIZE, 8, width of the address field and of both address pointers
DATA_SIZE, 8, width of one RAM word and of each data field in a frame
MEM_DEPTH, 256, number of RAM words; must be <= 2**ADDR_SIZE
AUTO_INC, 1, 1 = pointer advances after each burst word; 0 = pointer holds

Ports:
clk  input  1  system clock; all logic on posedge
RST  input  1  synchronous active-high reset
SS_N  input  1  slave select, active low; frames a transaction
MOSI  input  1  serial data from master, MSB first
MISO  output  1  serial read data to master, MSB first
busy  output  1  high while the FSM is not in IDLE
frame_err  output  1  one-cycle pulse when SS_N rises mid-word

Behaviour:
- Reset (RST=1 at posedge): state=IDLE, MISO=0, busy=0, frame_err=0, wr_ptr=0, rd_ptr=0, shift and bit counters cleared. RAM contents are not cleared.
- Reset mid-frame aborts immediately; no RAM write occurs in that cycle.
- Frame timing, counted in cycles from the first posedge with SS_N=0:
  - cycle 0: IDLE->CHK_CMD; MOSI is ignored.
  - cycles 1-2: 2-bit command, MSB first.
  - cycle 3 onward: payload.
- Commands and states:
  - 00 -> WR_ADDR: ADDR_SIZE bits are loaded into wr_ptr. Later bits are ignored until SS_N rises.
  - 01 -> WR_DATA: each DATA_SIZE-bit word is written to RAM[wr_ptr] on the posedge that samples its last bit. wr_ptr then advances if AUTO_INC=1. Repeats while SS_N stays low (burst).
  - 10 -> RD_ADDR: ADDR_SIZE bits are loaded into rd_ptr.
  - 11 -> RD_DATA: cycle 3 is a dummy cycle (synchronous RAM read of RAM[rd_ptr]); MOSI is ignored. MISO shows the word MSB first starting at the posedge ending cycle 3, one bit per cycle. On the posedge that shifts out the last bit, rd_ptr advances (if AUTO_INC=1) and the next word is prefetched, so burst words stream back to back with no gap.
- Pointer wrap: the increment past MEM_DEPTH-1 returns to 0.
- Addresses >= MEM_DEPTH on load are taken modulo MEM_DEPTH.
- SS_N high in any non-IDLE state -> IDLE on the next posedge.
  - If a WR_ADDR, RD_ADDR or WR_DATA word is partially shifted (bit count 1..N-1), that word is discarded (no pointer load, no RAM write) and frame_err pulses for 1 cycle.
  - SS_N rising during CHK_CMD or RD_DATA does not pulse frame_err.
- MISO is 0 whenever the block is not in RD_DATA past the dummy cycle.
- busy = (state != IDLE).
- A write and a read never occur in the same cycle (single port).

Decomposition:
- Shared package spi_ram_pkg holds:
  - state encoding (IDLE, CHK_CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA), 3-bit
  - command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
- One sub-module, spi_ram_core: parametrised single-port synchronous RAM (clk, we, addr, din, dout; no reset).
- The top level holds the FSM, shift registers, counters and pointers.

Test Plan:
1. Write-addr frame 00+0x10, then write-data frame 01+0xDE+0xAD -> RAM[0x10]=0xDE, RAM[0x11]=0xAD, wr_ptr=0x12, frame_err never pulses.
2. After scenario 1: read-addr frame 10+0x10, then read-data frame 11 with 16 payload cycles -> after the cycle-3 dummy, MISO = 1101_1110 then 1010_1101 contiguous, rd_ptr=0x12.
3. Wrap: wr_ptr=0xFF, write-data burst 0x11,0x22 -> RAM[0xFF]=0x11, RAM[0x00]=0x22, wr_ptr=0x01.
4. Abort: wr_ptr=0x30, write-data frame with 5 payload bits then SS_N=1 -> RAM[0x30] unchanged, frame_err=1 for exactly 1 cycle, wr_ptr=0x30, busy=0 the next cycle.
5. RST=1 during the 4th MISO bit of a read burst -> next cycle MISO=0, busy=0, wr_ptr=rd_ptr=0. RAM[0x10] still reads 0xDE in a following frame.
6. AUTO_INC=0 build: wr_ptr=0x20, burst 0xAA,0x55 -> RAM[0x20]=0x55, RAM[0x21] untouched. Read burst of 2 words returns 0x55 twice.
